// File: rtl/cache_mem_responder.sv
// ---------------------------------------------------------------------------
// cache_mem_responder
//   Main-memory model for the far side of the cache memory interface. It
//   accepts single-cycle line requests (refill reads, write-backs), holds
//   each one for LATENCY cycles, commits writes to a behavioural line array
//   and answers with a one-cycle ready pulse. Read data is held until the
//   next read completes. It also keeps read/write counters and a sticky
//   protocol-error flag.
//
// Ports:
//   clk_i, rst_ni   clock (rising edge), async active-low reset
//   req_valid_i     request strobe (may be a single-cycle pulse)
//   req_rw_i        1 = write-back, 0 = refill read
//   req_addr_i      byte address; line index = addr[IDX_W+3:4]
//   req_data_i      write line data
//   resp_ready_o    one-cycle completion pulse
//   resp_data_o     last read line
//   rd_cnt_o        completed reads (wrapping)
//   wr_cnt_o        completed writes (wrapping)
//   proto_err_o     sticky: request seen while busy
// ---------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    input  logic         req_rw_i,
    input  logic [31:0]  req_addr_i,
    input  logic [127:0] req_data_i,
    output logic         resp_ready_o,
    output logic [127:0] resp_data_o,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o,
    output logic         proto_err_o
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   pend_idx_q;
    logic               pend_rw_q;
    logic [127:0]       pend_data_q;
    logic [127:0]       resp_data_q;
    logic [31:0]        rd_cnt_q, wr_cnt_q;
    logic               proto_err_q;

    logic [127:0]       mem [DEPTH_LINES];

    logic [IDX_W-1:0]   req_idx;
    logic               accept, commit, err_set;
    logic [IDX_W-1:0]   c_idx;
    logic               c_rw;
    logic [127:0]       c_data;

    assign req_idx = req_addr_i[IDX_W+3:4];

    // Offset and alias bits of the address carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:IDX_W+4], req_addr_i[3:0]};

    // cnt_q counts the WAIT edges still to pass before the RESP edge, so a
    // request accepted at E0 enters RESP exactly at edge E_LATENCY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        err_set = 1'b0;
        c_idx   = pend_idx_q;
        c_rw    = pend_rw_q;
        c_data  = pend_data_q;
        case (state_q)
            S_IDLE: accept = req_valid_i;
            S_RESP: begin
                accept = req_valid_i;
                if (!req_valid_i) state_d = S_IDLE;
            end
            S_WAIT: begin
                err_set = req_valid_i;
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            if (LATENCY == 1) begin
                // Zero-wait case: the incoming request completes at this very
                // edge, so commit/lookup uses the live inputs, not pending.
                state_d = S_RESP;
                commit  = 1'b1;
                c_idx   = req_idx;
                c_rw    = req_rw_i;
                c_data  = req_data_i;
            end else begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_idx_q  <= '0;
            pend_rw_q   <= 1'b0;
            pend_data_q <= '0;
            resp_data_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_idx_q  <= req_idx;
                pend_rw_q   <= req_rw_i;
                pend_data_q <= req_data_i;
            end
            if (commit) begin
                if (c_rw) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_q    <= rd_cnt_q + 32'd1;
                    resp_data_q <= mem[c_idx];
                end
            end
            if (err_set) proto_err_q <= 1'b1;
        end
    end

    // Backing array: never reset, contents survive rst_ni. The rst_ni gate
    // keeps a write from landing while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commit && c_rw) mem[c_idx] <= c_data;
    end

    assign resp_ready_o = (state_q == S_RESP);
    assign resp_data_o  = resp_data_q;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign proto_err_o  = proto_err_q;

endmodule
